// File: rtl/wb_arb_6to2_if.sv
// wb_arb_6to2_if
//   Bus bundle for the 6-source to 2-port writeback arbiter.
//   Ports (as seen by the arbiter, modport slave):
//     src_valid_i[5:0]   in  : per-source result valid (bit k = source k)
//     src_data_i         in  : source k data at [k*DATA_WIDTH +: DATA_WIDTH]
//     src_ready_o[5:0]   out : per-source ready (buffer k not full)
//     wb1_en_o/wb2_en_o  out : writeback port valid, one cycle per grant
//     wb1_data_o/wb2_data_o out : writeback data
//     wb1_src_o/wb2_src_o   out : index (0-5) of the granted source
//     busy_o             out : any buffer non-empty or any writeback valid
//   modport master is the mirror view used by the producer/consumer side.
interface wb_arb_6to2_if #(
  parameter int DATA_WIDTH = 32
);
  logic [5:0]              src_valid_i;
  logic [6*DATA_WIDTH-1:0] src_data_i;
  logic [5:0]              src_ready_o;
  logic                    wb1_en_o;
  logic [DATA_WIDTH-1:0]   wb1_data_o;
  logic [2:0]              wb1_src_o;
  logic                    wb2_en_o;
  logic [DATA_WIDTH-1:0]   wb2_data_o;
  logic [2:0]              wb2_src_o;
  logic                    busy_o;

  modport slave (
    input  src_valid_i, src_data_i,
    output src_ready_o,
    output wb1_en_o, wb1_data_o, wb1_src_o,
    output wb2_en_o, wb2_data_o, wb2_src_o,
    output busy_o
  );

  modport master (
    output src_valid_i, src_data_i,
    input  src_ready_o,
    input  wb1_en_o, wb1_data_o, wb1_src_o,
    input  wb2_en_o, wb2_data_o, wb2_src_o,
    input  busy_o
  );
endinterface

// File: rtl/wb_arb_6to2.sv
// wb_arb_6to2
//   Six result sources, each buffered in its own DEPTH-entry FIFO, are
//   arbitrated onto two registered writeback ports per cycle. The first two
//   non-empty buffers found in the scan are granted (port 1 first, port 2
//   second); the scan starts at a round-robin pointer that moves past the
//   last granted source.
//   Ports:
//     clk  : single clock, all state on posedge
//     rst  : synchronous, active-high reset
//     bus  : wb_arb_6to2_if.slave (source handshake, writeback ports, busy)
//   Configuration:
//     WB_ARB_FIXED_PRIO_EN defined -> fixed priority, source 0 highest,
//     scan always starts at 0. Undefined (default) -> round-robin.
module wb_arb_6to2 #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic               clk,
  input  logic               rst,
  wb_arb_6to2_if.slave       bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Per-source FIFO storage and control
  logic [DATA_WIDTH-1:0] mem_q  [6][DEPTH];
  logic [PW-1:0]         wptr_q [6];
  logic [PW-1:0]         rptr_q [6];
  logic [CW-1:0]         cnt_q  [6];
  logic [CW-1:0]         cnt_d  [6];

  logic [5:0] ready;
  logic [5:0] nonempty;
  logic [5:0] push;
  logic [5:0] pop;

  // Arbitration results
  logic [2:0] start;
  logic       g1_vld, g2_vld;
  logic [2:0] g1_idx, g2_idx;
  logic [DATA_WIDTH-1:0] head1, head2;

  // Registered writeback ports
  logic                  wb1_en_q,   wb2_en_q;
  logic [DATA_WIDTH-1:0] wb1_data_q, wb2_data_q;
  logic [2:0]            wb1_src_q,  wb2_src_q;

  // Ready and occupancy come only from registered counts, so there is no
  // combinational path from src_valid_i to src_ready_o.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      ready[k]    = (cnt_q[k] != CW'(DEPTH));
      nonempty[k] = (cnt_q[k] != '0);
      push[k]     = bus.src_valid_i[k] && ready[k] && !rst;
    end
  end

`ifdef WB_ARB_FIXED_PRIO_EN
  assign start = 3'd0;
`else
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] last_idx;

  // Pointer moves one past the last granted source so that source gets the
  // lowest priority next cycle.
  always_comb begin
    last_idx = g2_vld ? g2_idx : g1_idx;
    rr_ptr_d = rr_ptr_q;
    if (g1_vld) begin
      rr_ptr_d = (last_idx == 3'd5) ? 3'd0 : last_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 3'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign start = rr_ptr_q;
`endif

  // Scan six positions from start with wrap 5->0; first hit is grant 1,
  // second hit is grant 2, so the two grants can never coincide.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    g1_vld = 1'b0;
    g2_vld = 1'b0;
    g1_idx = 3'd0;
    g2_idx = 3'd0;
    sum    = 4'd0;
    idx    = 3'd0;
    for (int i = 0; i < 6; i++) begin
      sum = {1'b0, start} + 4'(i);
      idx = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
      if (nonempty[idx]) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = idx;
        end else if (!g2_vld) begin
          g2_vld = 1'b1;
          g2_idx = idx;
        end
      end
    end
  end

  always_comb begin
    head1 = '0;
    head2 = '0;
    for (int k = 0; k < 6; k++) begin
      pop[k] = (g1_vld && (g1_idx == 3'(k))) || (g2_vld && (g2_idx == 3'(k)));
      if (g1_idx == 3'(k)) head1 = mem_q[k][rptr_q[k]];
      if (g2_idx == 3'(k)) head2 = mem_q[k][rptr_q[k]];
    end
  end

  // Simultaneous push and pop leaves the count unchanged.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      cnt_d[k] = cnt_q[k];
      if (push[k] && !pop[k]) cnt_d[k] = cnt_q[k] + CW'(1);
      if (pop[k] && !push[k]) cnt_d[k] = cnt_q[k] - CW'(1);
    end
  end

  // ---- stage boundary: FIFO state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 6; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (push[k]) wptr_q[k] <= wptr_q[k] + PW'(1);
        if (pop[k])  rptr_q[k] <= rptr_q[k] + PW'(1);
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (push[k]) mem_q[k][wptr_q[k]] <= bus.src_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // ---- stage boundary: writeback registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wb1_en_q   <= 1'b0;
      wb1_data_q <= '0;
      wb1_src_q  <= 3'd0;
      wb2_en_q   <= 1'b0;
      wb2_data_q <= '0;
      wb2_src_q  <= 3'd0;
    end else begin
      wb1_en_q   <= g1_vld;
      wb1_data_q <= g1_vld ? head1 : '0;
      wb1_src_q  <= g1_vld ? g1_idx : 3'd0;
      wb2_en_q   <= g2_vld;
      wb2_data_q <= g2_vld ? head2 : '0;
      wb2_src_q  <= g2_vld ? g2_idx : 3'd0;
    end
  end

  assign bus.src_ready_o = ready;
  assign bus.wb1_en_o    = wb1_en_q;
  assign bus.wb1_data_o  = wb1_data_q;
  assign bus.wb1_src_o   = wb1_src_q;
  assign bus.wb2_en_o    = wb2_en_q;
  assign bus.wb2_data_o  = wb2_data_q;
  assign bus.wb2_src_o   = wb2_src_q;
  assign bus.busy_o      = (|nonempty) || wb1_en_q || wb2_en_q;

endmodule

// File: tb/tb_wb_arb_6to2.sv
module tb_wb_arb_6to2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arb_6to2_if #(.DATA_WIDTH(DW)) bus ();

  wb_arb_6to2 #(.DATA_WIDTH(DW), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            port;
    int            src;
    logic [DW-1:0] data;
  } out_t;

  typedef struct {
    int         cyc;
    int         kind;   // 0: state snapshot, 1: scoreboard drained
    string      name;
    logic [5:0] ready;
    logic       busy;
    logic       e1;
    logic       e2;
  } st_t;

  out_t exp_q[$];
  st_t  st_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every writeback beat and every scheduled state check.
  task automatic chk_out(input int port, input logic [2:0] src, input logic [DW-1:0] data);
    out_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL wb%0d_unexpected: got src=%0d data=%h, required no output", port, src, data);
    end else begin
      e = exp_q.pop_front();
      if (e.port != port || e.src != int'(src) || e.data !== data) begin
        errors++;
        $display("FAIL wb%0d_beat: got port=%0d src=%0d data=%h, required port=%0d src=%0d data=%h",
                 port, port, src, data, e.port, e.src, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    st_t s;
    if (bus.wb1_en_o === 1'b1) chk_out(1, bus.wb1_src_o, bus.wb1_data_o);
    if (bus.wb2_en_o === 1'b1) chk_out(2, bus.wb2_src_o, bus.wb2_data_o);
    while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
      s = st_q.pop_front();
      checks++;
      if (s.kind == 1) begin
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL %s: got %0d outstanding beats, required 0", s.name, exp_q.size());
          exp_q.delete();
        end
      end else if ({bus.src_ready_o, bus.busy_o, bus.wb1_en_o, bus.wb2_en_o} !==
                   {s.ready, s.busy, s.e1, s.e2}) begin
        errors++;
        $display("FAIL %s: got ready=%b busy=%b en1=%b en2=%b, required ready=%b busy=%b en1=%b en2=%b",
                 s.name, bus.src_ready_o, bus.busy_o, bus.wb1_en_o, bus.wb2_en_o,
                 s.ready, s.busy, s.e1, s.e2);
      end
    end
  end

  // Stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] v);
    bus.src_data_i[k*DW +: DW] = v;
  endtask

  task automatic exp_out(input int port, input int src, input logic [DW-1:0] data);
    out_t e;
    e.port = port;
    e.src  = src;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic exp_state(input string nm, input logic [5:0] rdy, input logic bsy,
                           input logic en1, input logic en2);
    st_t s;
    s.cyc = cyc; s.kind = 0; s.name = nm;
    s.ready = rdy; s.busy = bsy; s.e1 = en1; s.e2 = en2;
    st_q.push_back(s);
  endtask

  task automatic drain(input string nm);
    st_t s;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    s.cyc = cyc; s.kind = 1; s.name = nm;
    s.ready = '0; s.busy = 1'b0; s.e1 = 1'b0; s.e2 = 1'b0;
    st_q.push_back(s);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    bus.src_valid_i = '0;
    step();
    rst = 1'b0;
    exp_state(nm, 6'h3F, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [5:0] rdy;
    int w0, w1, w5;
    bus.src_valid_i = '0;
    bus.src_data_i  = '0;
    step();

    // Single source, single word: latency and port-1-only grant
    do_reset("reset_init");
    set_data(3, 32'hA5A5_0003);
    bus.src_valid_i = 6'b001000;
    exp_out(1, 3, 32'hA5A5_0003);
    step();
    bus.src_valid_i = '0;
    exp_state("t1_after_push", 6'h3F, 1'b1, 1'b0, 1'b0);
    step();
    exp_state("t1_wb", 6'h3F, 1'b1, 1'b1, 1'b0);
    step();
    exp_state("t1_idle", 6'h3F, 1'b0, 1'b0, 1'b0);
    drain("t1_drain");

    // All six push together: pairs (0,1),(2,3),(4,5)
    do_reset("reset_t2");
    for (int k = 0; k < 6; k++) set_data(k, 32'h1000_0000 + DW'(k));
    bus.src_valid_i = 6'h3F;
    for (int k = 0; k < 6; k++) exp_out((k % 2) + 1, k, 32'h1000_0000 + DW'(k));
    step();
    bus.src_valid_i = '0;
    exp_state("t2_push", 6'h3F, 1'b1, 1'b0, 1'b0);
    step();
    exp_state("t2_g01", 6'h3F, 1'b1, 1'b1, 1'b1);
    step();
    exp_state("t2_g23", 6'h3F, 1'b1, 1'b1, 1'b1);
    step();
    exp_state("t2_g45", 6'h3F, 1'b1, 1'b1, 1'b1);
    step();
    exp_state("t2_idle", 6'h3F, 1'b0, 1'b0, 1'b0);
    drain("t2_drain");

    // Source 2 overfill: third word refused while buffer full
    do_reset("reset_t3");
    for (int k = 0; k < 6; k++) set_data(k, 32'h2000_0000 + DW'(k));
    set_data(2, 32'h2222_0001);
    bus.src_valid_i = 6'h3F;
    exp_out(1, 0, 32'h2000_0000);
    exp_out(2, 1, 32'h2000_0001);
    exp_out(1, 2, 32'h2222_0001);
    exp_out(2, 3, 32'h2000_0003);
    exp_out(1, 4, 32'h2000_0004);
    exp_out(2, 5, 32'h2000_0005);
    exp_out(1, 2, 32'h2222_0002);
    step();
    exp_state("t3_e1", 6'h3F, 1'b1, 1'b0, 1'b0);
    bus.src_valid_i = 6'b000100;
    set_data(2, 32'h2222_0002);
    step();
    exp_state("t3_full", 6'b111011, 1'b1, 1'b1, 1'b1);
    set_data(2, 32'h2222_0003);
    step();
    bus.src_valid_i = '0;
    exp_state("t3_e3", 6'h3F, 1'b1, 1'b1, 1'b1);
    drain("t3_drain");

    // Sources 1 and 4 streaming concurrently
    do_reset("reset_t4");
    for (int i = 1; i <= 4; i++) begin
      set_data(1, DW'(i));
      set_data(4, 32'h40 + DW'(i));
      bus.src_valid_i = 6'b010010;
      exp_out(1, 1, DW'(i));
      exp_out(2, 4, 32'h40 + DW'(i));
      step();
      if (i == 3) exp_state("t4_stream", 6'h3F, 1'b1, 1'b1, 1'b1);
    end
    bus.src_valid_i = '0;
    drain("t4_drain");

    // Reset with four buffers non-empty; valid during reset ignored
    do_reset("reset_t5");
    for (int k = 0; k < 4; k++) set_data(k, 32'h3000_0001 + DW'(k * 16));
    bus.src_valid_i = 6'b001111;
    step();
    for (int k = 0; k < 4; k++) set_data(k, 32'h3000_0002 + DW'(k * 16));
    exp_out(1, 0, 32'h3000_0001);
    exp_out(2, 1, 32'h3000_0011);
    step();
    exp_state("t5_loaded", 6'b110011, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    bus.src_valid_i = 6'h3F;
    step();
    exp_state("t5_in_rst", 6'h3F, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.src_valid_i = '0;
    step();
    exp_state("t5_after_rst", 6'h3F, 1'b0, 1'b0, 1'b0);
    drain("t5_drain");

    // Sources 0, 1, 5 held valid for four cycles
    do_reset("reset_t6");
`ifdef WB_ARB_FIXED_PRIO_EN
    exp_out(1, 0, 32'h5000_0001); exp_out(2, 1, 32'h5000_0101);
    exp_out(1, 0, 32'h5000_0002); exp_out(2, 1, 32'h5000_0102);
    exp_out(1, 0, 32'h5000_0003); exp_out(2, 1, 32'h5000_0103);
    exp_out(1, 0, 32'h5000_0004); exp_out(2, 1, 32'h5000_0104);
    exp_out(1, 5, 32'h5000_0501);
    exp_out(1, 5, 32'h5000_0502);
`else
    exp_out(1, 0, 32'h5000_0001); exp_out(2, 1, 32'h5000_0101);
    exp_out(1, 5, 32'h5000_0501); exp_out(2, 0, 32'h5000_0002);
    exp_out(1, 1, 32'h5000_0102); exp_out(2, 5, 32'h5000_0502);
    exp_out(1, 0, 32'h5000_0003); exp_out(2, 1, 32'h5000_0103);
    exp_out(1, 5, 32'h5000_0503); exp_out(2, 0, 32'h5000_0004);
`endif
    w0 = 1; w1 = 1; w5 = 1;
    for (int c = 0; c < 4; c++) begin
      set_data(0, 32'h5000_0000 + DW'(w0));
      set_data(1, 32'h5000_0100 + DW'(w1));
      set_data(5, 32'h5000_0500 + DW'(w5));
      bus.src_valid_i = 6'b100011;
      rdy = bus.src_ready_o;
      step();
      if (rdy[0]) w0++;
      if (rdy[1]) w1++;
      if (rdy[5]) w5++;
    end
    bus.src_valid_i = '0;
    drain("t6_drain");

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arb_6to2.md
WB_ARB_6TO2 -- requirements
Module: wb_arb_6to2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each result word.
REQ-002 SHALL have parameter DEPTH, default 2, entries per source buffer (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port src_valid_i, input, 6, per-source result valid, bit k = source k.
REQ-006 SHALL have port src_data_i, input, 6*DATA_WIDTH, source k data at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port src_ready_o, output, 6, per-source ready; bit k high when buffer k not full.
REQ-008 SHALL have port wb1_en_o, output, 1, writeback port 1 valid.
REQ-009 SHALL have port wb1_data_o, output, DATA_WIDTH, writeback port 1 data.
REQ-010 SHALL have port wb2_en_o, output, 1, writeback port 2 valid.
REQ-011 SHALL have port wb2_data_o, output, DATA_WIDTH, writeback port 2 data.
REQ-012 SHALL have port wb1_src_o / wb2_src_o, output, 3 each, index (0-5) of granted source.
REQ-013 SHALL have port busy_o, output, 1, high when any buffer non-empty or any wb*_en_o high.

Function
REQ-014 SHALL hold one FIFO per source, DEPTH entries, with wrapping read/write pointers and an occupancy count.
REQ-015 SHALL push source k on a posedge where src_valid_i[k] and src_ready_o[k] are both high; valid with ready low is ignored (not stored, not lost-flagged).
REQ-016 SHALL drive src_ready_o[k] = (count_k != DEPTH), from registered state only (no combinational path from any input).
REQ-017 SHALL, each cycle, grant grant1 = first non-empty buffer scanning from rr_ptr upward with wrap 5->0, and grant2 = next non-empty buffer after grant1 in the same scan; grant2 never equals grant1.
REQ-018 SHALL pop granted buffers on the same posedge, registering head data into wb1_*/wb2_* with en high; ungranted ports register en=0, data=0, src=0.
REQ-019 SHALL, when only one buffer is non-empty, grant it on port 1 only (wb2_en_o=0), one entry per cycle.
REQ-020 SHALL advance rr_ptr to (last granted index + 1) mod 6 when any grant occurs; otherwise hold.
REQ-021 SHALL give latency: word pushed at edge N appears on wb outputs after edge N+1 at earliest.
REQ-022 SHALL support simultaneous push and pop on the same buffer in one cycle; count unchanged, order preserved (FIFO per source).
REQ-023 SHALL never reorder words from a single source; cross-source order is set only by arbitration.
REQ-024 SHALL keep wb*_en_o high for exactly one cycle per grant (no hold; downstream always accepts).

Reset
REQ-025 SHALL, while rst high at posedge, clear all counts and pointers, rr_ptr=0, wb1_en_o=wb2_en_o=0, wb*_data_o=0, wb*_src_o=0.
REQ-026 SHALL drop all buffered words on reset mid-operation; src_ready_o = 6'b111111 from the first cycle after reset.
REQ-027 SHALL ignore src_valid_i during any cycle rst is high.

Configuration
REQ-028 SHALL, with macro WB_ARB_FIXED_PRIO_EN defined, use fixed priority (source 0 highest, scan always starts at 0, rr_ptr unused).
REQ-029 SHALL, without WB_ARB_FIXED_PRIO_EN, use round-robin per REQ-017/REQ-020.

Verification
REQ-030 SHALL cover: reset, then src 3 pushes 0xA5A5_0003 -> next-next cycle wb1_en_o=1, wb1_data_o=0xA5A5_0003, wb1_src_o=3, wb2_en_o=0.
REQ-031 SHALL cover: all 6 sources push one word same cycle, rr_ptr=0 -> grants (0,1),(2,3),(4,5) on three consecutive cycles, busy_o low afterwards.
REQ-032 SHALL cover: source 2 pushes 3 words back-to-back, DEPTH=2, no pops possible (other 5 sources kept non-empty ahead) -> src_ready_o[2]=0 after 2 words, third word not stored.
REQ-033 SHALL cover: source 1 continuously valid with data 1,2,3,4 while source 4 also streams -> each source's outputs in order, alternating fairness, no word duplicated or dropped.
REQ-034 SHALL cover: rst asserted with 4 buffers non-empty -> next cycle wb*_en_o=0, src_ready_o=6'b111111, busy_o=0.
REQ-035 SHALL cover: build with WB_ARB_FIXED_PRIO_EN, sources 0,1,5 permanently valid -> only sources 0 and 1 ever granted.
